// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// opcode/funct values, datapath select codes and instruction-class indices.
package mc_ctrl_fsm_pkg;

    // Controller states; encodings 5..7 are illegal and recover to FETCH.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0]).
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Next-PC source.
    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_J26  = 2'd2;
    localparam logic [1:0] NPC_JR   = 2'd3;

    // ALU operation.
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;

    // GRF write-data source.
    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_DM    = 2'd1;
    localparam logic [1:0] WD_PC4   = 2'd2;

    // GRF destination register select.
    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_LINK = 2'd2;

    // Immediate extension.
    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    // Bit positions inside the one-hot instruction-class vector.
    localparam int CLS_RCAL = 0;
    localparam int CLS_ORI  = 1;
    localparam int CLS_LUI  = 2;
    localparam int CLS_LW   = 3;
    localparam int CLS_SW   = 4;
    localparam int CLS_BEQ  = 5;
    localparam int CLS_J    = 6;
    localparam int CLS_JAL  = 7;
    localparam int CLS_JR   = 8;
    localparam int CLS_NOP  = 9;
    localparam int CLS_N    = 10;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Instruction classifier: maps the IR contents onto exactly one class bit.
// Anything outside the supported ISA (including all-zero) lands in NOP.
module mc_ctrl_fsm_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [31:0]      instr,
    output logic [CLS_N-1:0] cls,
    output logic             rcal_sub
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // Opcode/funct decode into a one-hot class; fall-through is NOP.
    always_comb begin
        cls      = '0;
        rcal_sub = 1'b0;
        if (instr == 32'd0) begin
            cls[CLS_NOP] = 1'b1;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    if (funct == FN_ADDU) begin
                        cls[CLS_RCAL] = 1'b1;
                    end else if (funct == FN_SUBU) begin
                        cls[CLS_RCAL] = 1'b1;
                        rcal_sub      = 1'b1;
                    end else if (funct == FN_JR) begin
                        cls[CLS_JR] = 1'b1;
                    end else begin
                        cls[CLS_NOP] = 1'b1;
                    end
                end
                OP_ORI:  cls[CLS_ORI] = 1'b1;
                OP_LUI:  cls[CLS_LUI] = 1'b1;
                OP_LW:   cls[CLS_LW]  = 1'b1;
                OP_SW:   cls[CLS_SW]  = 1'b1;
                OP_BEQ:  cls[CLS_BEQ] = 1'b1;
                OP_J:    cls[CLS_J]   = 1'b1;
                OP_JAL:  cls[CLS_JAL] = 1'b1;
                default: cls[CLS_NOP] = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB, drives
// every datapath enable and select, and counts retired instructions.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int LINK_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    output logic             pc_en,
    output logic [1:0]       npc_sel,
    output logic             ir_we,
    output logic             grf_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [2:0]       alu_op,
    output logic             alu_src_b,
    output logic             ext_op,
    output logic             dm_we,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    // The datapath routes reg_dst = DST_LINK to this register; it must be a
    // writable GRF entry.
    if (LINK_REG < 1 || LINK_REG > 31) begin : g_bad_link_reg
        $error("LINK_REG must select a writable GRF register (1..31)");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             retire;
    logic [CLS_N-1:0] cls;
    logic             rcal_sub;

    mc_ctrl_fsm_decode u_decode (
        .instr    (instr),
        .cls      (cls),
        .rcal_sub (rcal_sub)
    );

    // Next-state, retirement and Moore output decode; reset overrides all.
    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        pc_en     = 1'b0;
        npc_sel   = NPC_PC4;
        ir_we     = 1'b0;
        grf_we    = 1'b0;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALU;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        ext_op    = EXT_ZERO;
        dm_we     = 1'b0;

        // ALU setup follows the instruction class once the IR is valid, so
        // operands are stable from DECODE through write-back.
        if (state_q != ST_FETCH) begin
            if (cls[CLS_RCAL]) begin
                alu_op = rcal_sub ? ALU_SUB : ALU_ADD;
            end else if (cls[CLS_ORI]) begin
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
                ext_op    = EXT_ZERO;
            end else if (cls[CLS_LUI]) begin
                alu_op    = ALU_LUI;
                alu_src_b = 1'b1;
                ext_op    = EXT_ZERO;
            end else if (cls[CLS_LW] || cls[CLS_SW]) begin
                alu_op    = ALU_ADD;
                alu_src_b = 1'b1;
                ext_op    = EXT_SIGN;
            end else if (cls[CLS_BEQ]) begin
                alu_op    = ALU_SUB;
                alu_src_b = 1'b0;
            end
        end

        case (state_q)
            ST_FETCH: begin
                // PC+4 is committed here for every instruction.
                ir_we   = 1'b1;
                pc_en   = 1'b1;
                npc_sel = NPC_PC4;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls[CLS_J]) begin
                    pc_en   = 1'b1;
                    npc_sel = NPC_J26;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls[CLS_JAL]) begin
                    // PC+4 register still holds this instruction's link value.
                    pc_en   = 1'b1;
                    npc_sel = NPC_J26;
                    grf_we  = 1'b1;
                    reg_dst = DST_LINK;
                    wd_sel  = WD_PC4;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls[CLS_JR]) begin
                    pc_en   = 1'b1;
                    npc_sel = NPC_JR;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls[CLS_NOP]) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls[CLS_BEQ]) begin
                    // Branch resolves here; retires whether taken or not.
                    npc_sel = NPC_BR;
                    pc_en   = alu_zero;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls[CLS_LW] || cls[CLS_SW]) begin
                    state_d = ST_MEM;
                end else if (cls[CLS_RCAL] || cls[CLS_ORI] || cls[CLS_LUI]) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (cls[CLS_SW]) begin
                    dm_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls[CLS_LW]) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB: begin
                if (cls[CLS_RCAL]) begin
                    grf_we  = 1'b1;
                    reg_dst = DST_RD;
                    wd_sel  = WD_ALU;
                    retire  = 1'b1;
                end else if (cls[CLS_ORI] || cls[CLS_LUI]) begin
                    grf_we  = 1'b1;
                    reg_dst = DST_RT;
                    wd_sel  = WD_ALU;
                    retire  = 1'b1;
                end else if (cls[CLS_LW]) begin
                    grf_we  = 1'b1;
                    reg_dst = DST_RT;
                    wd_sel  = WD_DM;
                    retire  = 1'b1;
                end
                state_d = ST_FETCH;
            end
            default: begin
                // Illegal encoding: recover silently, nothing enabled.
                state_d = ST_FETCH;
            end
        endcase

        // Reset abandons any in-flight instruction within the same cycle.
        if (reset) begin
            state_d   = ST_FETCH;
            retire    = 1'b0;
            pc_en     = 1'b0;
            npc_sel   = NPC_PC4;
            ir_we     = 1'b0;
            grf_we    = 1'b0;
            reg_dst   = DST_RT;
            wd_sel    = WD_ALU;
            alu_op    = ALU_ADD;
            alu_src_b = 1'b0;
            ext_op    = EXT_ZERO;
            dm_we     = 1'b0;
        end
    end

    // Retired-instruction counter, wrapping modulo 2^CNT_W.
    always_comb begin
        instr_cnt_d = instr_cnt_q + CNT_W'(retire);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the driver issues instructions and pushes
// the per-cycle expected control word from a path-table model; a monitor pops
// and compares one entry on every falling clock edge.
module tb_mc_ctrl_fsm;

    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 16;

    localparam logic [2:0] S_F = 3'd0;
    localparam logic [2:0] S_D = 3'd1;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3;
    localparam logic [2:0] S_W = 3'd4;

    localparam int K_ADDU = 0;
    localparam int K_SUBU = 1;
    localparam int K_ORI  = 2;
    localparam int K_LUI  = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_J    = 7;
    localparam int K_JAL  = 8;
    localparam int K_JR   = 9;
    localparam int K_NOP  = 10;
    localparam int K_UNK  = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instr;
    logic             alu_zero;
    logic             pc_en;
    logic [1:0]       npc_sel;
    logic             ir_we;
    logic             grf_we;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic [2:0]       alu_op;
    logic             alu_src_b;
    logic             ext_op;
    logic             dm_we;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    mc_ctrl_fsm #(.CNT_W(CNT_W), .LINK_REG(31)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .alu_zero  (alu_zero),
        .pc_en     (pc_en),
        .npc_sel   (npc_sel),
        .ir_we     (ir_we),
        .grf_we    (grf_we),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op),
        .dm_we     (dm_we),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       st;
        logic             pc_en, ir_we, grf_we, dm_we;
        logic [CNT_W-1:0] cnt;
        bit               c_npc;
        logic [1:0]       npc;
        bit               c_dst;
        logic [1:0]       dst;
        bit               c_wd;
        logic [1:0]       wd;
        bit               c_alu;
        logic [2:0]       aop;
        logic             srcb;
        bit               c_ext;
        logic             ext;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_on  = 1'b0;
    int   m_cnt   = 0;
    logic [2:0] m_state = S_F;

    function automatic int path_len(input int k);
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI, K_SW: return 4;
            K_LW:                               return 5;
            K_BEQ:                              return 3;
            default:                            return 2;
        endcase
    endfunction

    function automatic logic [2:0] path_state(input int k, input int i);
        case (i)
            0:       return S_F;
            1:       return S_D;
            2:       return S_E;
            3:       return (k == K_LW || k == K_SW) ? S_M : S_W;
            default: return S_W;
        endcase
    endfunction

    function automatic exp_t blank(input logic [2:0] st, input int cnt);
        exp_t e;
        e.st = st; e.cnt = CNT_W'(cnt);
        e.pc_en = 1'b0; e.ir_we = 1'b0; e.grf_we = 1'b0; e.dm_we = 1'b0;
        e.c_npc = 1'b0; e.npc = 2'd0; e.c_dst = 1'b0; e.dst = 2'd0;
        e.c_wd = 1'b0; e.wd = 2'd0; e.c_alu = 1'b0; e.aop = 3'd0;
        e.srcb = 1'b0; e.c_ext = 1'b0; e.ext = 1'b0;
        return e;
    endfunction

    function automatic exp_t expect_cycle(input int k, input int i, input logic az, input int cnt);
        exp_t e;
        e = blank(path_state(k, i), cnt);
        case (e.st)
            S_F: begin
                e.ir_we = 1'b1; e.pc_en = 1'b1; e.c_npc = 1'b1; e.npc = 2'd0;
            end
            S_D: begin
                if (k == K_J || k == K_JAL) begin
                    e.pc_en = 1'b1; e.c_npc = 1'b1; e.npc = 2'd2;
                end
                if (k == K_JAL) begin
                    e.grf_we = 1'b1; e.c_dst = 1'b1; e.dst = 2'd2; e.c_wd = 1'b1; e.wd = 2'd2;
                end
                if (k == K_JR) begin
                    e.pc_en = 1'b1; e.c_npc = 1'b1; e.npc = 2'd3;
                end
            end
            S_E: begin
                if (k == K_BEQ) begin
                    e.pc_en = az; e.c_npc = 1'b1; e.npc = 2'd1;
                    e.c_alu = 1'b1; e.aop = 3'd1; e.srcb = 1'b0;
                end
            end
            S_M: begin
                if (k == K_SW) e.dm_we = 1'b1;
            end
            default: begin
                e.grf_we = 1'b1; e.c_dst = 1'b1; e.c_wd = 1'b1; e.c_alu = 1'b1;
                case (k)
                    K_ADDU: begin e.dst = 2'd1; e.wd = 2'd0; e.aop = 3'd0; e.srcb = 1'b0; end
                    K_SUBU: begin e.dst = 2'd1; e.wd = 2'd0; e.aop = 3'd1; e.srcb = 1'b0; end
                    K_ORI:  begin e.dst = 2'd0; e.wd = 2'd0; e.aop = 3'd2; e.srcb = 1'b1;
                                  e.c_ext = 1'b1; e.ext = 1'b0; end
                    K_LUI:  begin e.dst = 2'd0; e.wd = 2'd0; e.aop = 3'd3; e.srcb = 1'b1;
                                  e.c_ext = 1'b1; e.ext = 1'b0; end
                    default: begin e.dst = 2'd0; e.wd = 2'd1; e.aop = 3'd0; e.srcb = 1'b1;
                                  e.c_ext = 1'b1; e.ext = 1'b1; end
                endcase
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] make_instr(input int k);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [5:0]  op, fn;
        rs  = 5'($urandom_range(0, 31));
        rt  = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        imm = 16'($urandom_range(0, 65535));
        tgt = 26'($urandom);
        case (k)
            K_ADDU: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            K_SUBU: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            K_ORI:  return {6'h0D, rs, rt, imm};
            K_LUI:  return {6'h0F, 5'd0, rt, imm};
            K_LW:   return {6'h23, rs, rt, imm};
            K_SW:   return {6'h2B, rs, rt, imm};
            K_BEQ:  return {6'h04, rs, rt, imm};
            K_J:    return {6'h02, tgt};
            K_JAL:  return {6'h03, tgt};
            K_JR:   return {6'h00, rs, 15'd0, 6'h08};
            K_NOP:  return 32'd0;
            default: begin
                case ($urandom_range(0, 2))
                    0: return 32'hFFFF_FFFF;
                    1: begin
                        do op = 6'($urandom_range(0, 63));
                        while (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h0D, 6'h0F, 6'h23, 6'h2B});
                        return {op, tgt};
                    end
                    default: begin
                        do fn = 6'($urandom_range(0, 63));
                        while (fn inside {6'h21, 6'h23, 6'h08});
                        return {6'h00, rs, rt, rd, 5'd0, fn};
                    end
                endcase
            end
        endcase
    endfunction

    task automatic drive_cycle(input logic [31:0] ins, input logic rst, input logic az, input exp_t e);
        instr    = ins;
        reset    = rst;
        alu_zero = az;
        sb.push_back(e);
        mon_on   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // az_mode: -1 random alu_zero, otherwise the forced value. stop < path
    // length leaves the instruction in flight.
    task automatic run_instr(input int k, input logic [31:0] ins, input int az_mode, input int stop);
        int len;
        int last;
        len  = path_len(k);
        last = (stop < len) ? stop : len;
        for (int i = 0; i < last; i++) begin
            logic        az;
            logic [31:0] cur;
            az  = (az_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(az_mode);
            cur = (i == 0) ? $urandom : ins;
            drive_cycle(cur, 1'b0, az, expect_cycle(k, i, az, m_cnt));
        end
        if (last == len) begin
            m_cnt   = (m_cnt + 1) % CNT_MOD;
            m_state = S_F;
        end else begin
            m_state = path_state(k, last);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e = blank(m_state, m_cnt);
            e.c_npc = 1'b1; e.c_dst = 1'b1; e.c_wd = 1'b1; e.c_alu = 1'b1; e.c_ext = 1'b1;
            drive_cycle($urandom, 1'b1, 1'($urandom_range(0, 1)), e);
            m_state = S_F;
            m_cnt   = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per clock, compared away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                cyc++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow cycle=%0d got=empty expected=entry", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("state",     32'(state),     32'(e.st));
                    chk("pc_en",     32'(pc_en),     32'(e.pc_en));
                    chk("ir_we",     32'(ir_we),     32'(e.ir_we));
                    chk("grf_we",    32'(grf_we),    32'(e.grf_we));
                    chk("dm_we",     32'(dm_we),     32'(e.dm_we));
                    chk("instr_cnt", 32'(instr_cnt), 32'(e.cnt));
                    if (e.c_npc) chk("npc_sel", 32'(npc_sel), 32'(e.npc));
                    if (e.c_dst) chk("reg_dst", 32'(reg_dst), 32'(e.dst));
                    if (e.c_wd)  chk("wd_sel",  32'(wd_sel),  32'(e.wd));
                    if (e.c_alu) begin
                        chk("alu_op",    32'(alu_op),    32'(e.aop));
                        chk("alu_src_b", 32'(alu_src_b), 32'(e.srcb));
                    end
                    if (e.c_ext) chk("ext_op", 32'(ext_op), 32'(e.ext));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // Driver: directed scenarios, counter wrap, then randomized traffic.
    initial begin
        int k;
        reset    = 1'b1;
        instr    = 32'd0;
        alu_zero = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        run_instr(K_ADDU, 32'h0022_1821, -1, 99);
        run_instr(K_LW,   make_instr(K_LW), -1, 99);
        run_instr(K_SW,   make_instr(K_SW), -1, 99);
        run_instr(K_BEQ,  make_instr(K_BEQ), 1, 99);
        run_instr(K_BEQ,  make_instr(K_BEQ), 0, 99);
        run_instr(K_JAL,  make_instr(K_JAL), -1, 99);
        run_instr(K_JR,   make_instr(K_JR), -1, 99);
        run_instr(K_UNK,  32'hFFFF_FFFF, -1, 99);
        run_instr(K_NOP,  32'd0, -1, 99);
        run_instr(K_SUBU, make_instr(K_SUBU), -1, 99);
        run_instr(K_ORI,  make_instr(K_ORI), -1, 99);
        run_instr(K_LUI,  make_instr(K_LUI), -1, 99);
        run_instr(K_J,    make_instr(K_J), -1, 99);

        // lw abandoned in MEM by a three-cycle reset.
        run_instr(K_LW, make_instr(K_LW), -1, 3);
        do_reset(3);

        // Sixteen retirements wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) run_instr(K_NOP, 32'd0, -1, 99);
        run_instr(K_UNK, make_instr(K_UNK), -1, 99);

        for (int i = 0; i < 90; i++) begin
            k = $urandom_range(0, 11);
            if ($urandom_range(0, 15) == 0) begin
                run_instr(k, make_instr(k), -1, $urandom_range(1, path_len(k) - 1));
                do_reset($urandom_range(1, 3));
            end else begin
                run_instr(k, make_instr(k), -1, 99);
            end
        end

        mon_on = 1'b0;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
